// File: rtl/pong_physics.sv
// Ball and paddle motion engine for the Pong datapath.
// Positions advance on an internal frame tick so motion speed is independent of clk.
// A MOVE tick can bounce the ball on both axes; leaving the screen on either side
// raises a one-cycle miss pulse and freezes the ball until the game FSM serves again.
module pong_physics #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_H    = 80,
    parameter int PADDLE1_X   = 20,
    parameter int PADDLE2_X   = 610,
    parameter int PADDLE_STEP = 4,
    parameter int BALL_STEP   = 2,
    parameter int TICK_DIV    = 416667
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stop,
    input  logic       serve,
    input  logic       up1,
    input  logic       down1,
    input  logic       up2,
    input  logic       down2,
    input  logic [1:0] speed_lvl,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic       miss1,
    output logic       miss2
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    // All geometry is evaluated in 11 bits so sums like x+BALL_SIZE+s never wrap.
    localparam logic [10:0] BALL_X0 = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y0 = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] PAD_Y0  = 11'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] P_MAX   = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] P_STEP  = 11'(PADDLE_STEP);
    localparam logic [10:0] B_SIZE  = 11'(BALL_SIZE);
    localparam logic [10:0] P_H     = 11'(PADDLE_H);
    localparam logic [10:0] L_FACE  = 11'(PADDLE1_X + PADDLE_W);
    localparam logic [10:0] R_FACE  = 11'(PADDLE2_X);
    localparam logic [10:0] B_STEP  = 11'(BALL_STEP);

    typedef enum logic [1:0] {
        ST_SERVE  = 2'd0,
        ST_MOVE   = 2'd1,
        ST_MISSED = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [9:0]       bx, by, p1, p2;
    logic [9:0]       bx_n, by_n, p1_n, p2_n;
    logic             dir_x, dir_y;       // dir_x 1 = right, dir_y 1 = down
    logic             dir_x_n, dir_y_n;
    logic             miss1_n, miss2_n;
    logic [10:0]      bx11, by11, s;
    logic             ov1, ov2, q;

    // Saturating paddle move; opposing or absent commands leave it in place.
    function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up,
                                               input logic dn);
        logic [10:0] y11;
        y11 = {1'b0, y};
        if (up && !dn)
            return (y11 <= P_STEP) ? 10'd0 : 10'(y11 - P_STEP);
        else if (dn && !up)
            return (y11 + P_STEP >= P_MAX) ? 10'(P_MAX) : 10'(y11 + P_STEP);
        return y;
    endfunction

    // Vertical overlap of ball and paddle spans, on pre-tick positions.
    function automatic logic overlap(input logic [10:0] ball_top, input logic [9:0] pad_top);
        logic [10:0] pt;
        pt = {1'b0, pad_top};
        return (ball_top + B_SIZE > pt) && (ball_top < pt + P_H);
    endfunction

    // Free-running frame tick divider, independent of stop and FSM state.
    always_ff @(posedge clk) begin
        if (rst || tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Derived tick and per-tick step quantities.
    always_comb begin
        tick = (cnt == CNT_LAST);
        q    = tick && !stop;
        s    = B_STEP + {9'd0, speed_lvl};
        bx11 = {1'b0, bx};
        by11 = {1'b0, by};
        ov1  = overlap(by11, p1);
        ov2  = overlap(by11, p2);
    end

    // Next-state and next-position logic for the SERVE / MOVE / MISSED FSM.
    always_comb begin
        state_n = state;
        bx_n    = bx;
        by_n    = by;
        p1_n    = p1;
        p2_n    = p2;
        dir_x_n = dir_x;
        dir_y_n = dir_y;
        miss1_n = 1'b0;
        miss2_n = 1'b0;
        case (state)
            ST_SERVE: begin
                if (q) begin
                    p1_n    = paddle_next(p1, up1, down1);
                    p2_n    = paddle_next(p2, up2, down2);
                    state_n = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (q) begin
                    p1_n = paddle_next(p1, up1, down1);
                    p2_n = paddle_next(p2, up2, down2);
                    if (dir_y) begin
                        if (by11 + s >= Y_MAX) begin
                            by_n    = 10'(Y_MAX);
                            dir_y_n = 1'b0;
                        end else begin
                            by_n = 10'(by11 + s);
                        end
                    end else begin
                        if (by11 <= s) begin
                            by_n    = 10'd0;
                            dir_y_n = 1'b1;
                        end else begin
                            by_n = 10'(by11 - s);
                        end
                    end
                    // Face checks require the ball to start on the playfield side of the
                    // face, so a ball already past a paddle can never be pulled back.
                    if (!dir_x) begin
                        if (bx11 >= L_FACE && bx11 <= L_FACE + s && ov1) begin
                            bx_n    = 10'(L_FACE);
                            dir_x_n = 1'b1;
                        end else if (bx11 <= s) begin
                            bx_n    = 10'd0;
                            miss1_n = 1'b1;
                            state_n = ST_MISSED;
                        end else begin
                            bx_n = 10'(bx11 - s);
                        end
                    end else begin
                        if (bx11 + B_SIZE <= R_FACE && bx11 + B_SIZE + s >= R_FACE && ov2) begin
                            bx_n    = 10'(R_FACE - B_SIZE);
                            dir_x_n = 1'b0;
                        end else if (bx11 + s >= X_MAX) begin
                            bx_n    = 10'(X_MAX);
                            miss2_n = 1'b1;
                            state_n = ST_MISSED;
                        end else begin
                            bx_n = 10'(bx11 + s);
                        end
                    end
                end
            end
            ST_MISSED: begin
                // dir_x is left untouched: a left exit only happens while moving left
                // and a right exit while moving right, so it already points at the
                // player who missed.
                if (serve) begin
                    bx_n    = 10'(BALL_X0);
                    by_n    = 10'(BALL_Y0);
                    dir_y_n = 1'b1;
                    state_n = ST_SERVE;
                end
            end
            default: state_n = ST_SERVE;
        endcase
    end

    // State, position and miss-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SERVE;
            bx    <= 10'(BALL_X0);
            by    <= 10'(BALL_Y0);
            p1    <= 10'(PAD_Y0);
            p2    <= 10'(PAD_Y0);
            dir_x <= 1'b1;
            dir_y <= 1'b1;
            miss1 <= 1'b0;
            miss2 <= 1'b0;
        end else begin
            state <= state_n;
            bx    <= bx_n;
            by    <= by_n;
            p1    <= p1_n;
            p2    <= p2_n;
            dir_x <= dir_x_n;
            dir_y <= dir_y_n;
            miss1 <= miss1_n;
            miss2 <= miss2_n;
        end
    end

    assign ball_x    = bx;
    assign ball_y    = by;
    assign paddle1_y = p1;
    assign paddle2_y = p2;

endmodule

// File: tb/tb_pong_physics.sv
// Directed bench for pong_physics with a 4-cycle frame tick.
// Expected values are queued as stimulus is applied and checked once the DUT has
// produced the corresponding outputs.
module tb_pong_physics;

    localparam int SEL_BX = 0;
    localparam int SEL_BY = 1;
    localparam int SEL_P1 = 2;
    localparam int SEL_P2 = 3;
    localparam int SEL_M1 = 4;
    localparam int SEL_M2 = 5;

    logic       clk = 1'b0;
    logic       rst, stop, serve, up1, down1, up2, down2;
    logic [1:0] speed_lvl;
    logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
    logic       miss1, miss2;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   phase  = 0;   // bench's own view of the tick divider
    logic ticked = 1'b0;

    pong_physics #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .stop(stop), .serve(serve),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .speed_lvl(speed_lvl),
        .ball_x(ball_x), .ball_y(ball_y),
        .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .miss1(miss1), .miss2(miss2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_BX:  return {22'd0, ball_x};
            SEL_BY:  return {22'd0, ball_y};
            SEL_P1:  return {22'd0, paddle1_y};
            SEL_P2:  return {22'd0, paddle2_y};
            SEL_M1:  return {31'd0, miss1};
            default: return {31'd0, miss2};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_run++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    // One clock; sample 1 time unit after the edge and track the divider phase.
    task automatic clk1();
        @(posedge clk);
        #1;
        ticked = !rst && (phase == 3);
        if (rst || phase == 3) phase = 0;
        else phase = phase + 1;
    endtask

    task automatic next_tick();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            clk1();
            got = ticked;
        end
        if (!got) begin
            n_run++;
            assert (got) else begin
                n_fail++;
                $error("FAIL tick_timeout: observed 0, expected 1");
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    task automatic push_reset_vals(input string tag);
        push({tag, "_bx"}, SEL_BX, 316);
        push({tag, "_by"}, SEL_BY, 236);
        push({tag, "_p1"}, SEL_P1, 200);
        push({tag, "_p2"}, SEL_P2, 200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stop = 1'b1; serve = 1'b0;
        up1 = 1'b0; down1 = 1'b0; up2 = 1'b0; down2 = 1'b0;
        speed_lvl = 2'd0;

        // Reset state
        clk1(); clk1();
        push_reset_vals("rst");
        push("rst_m1", SEL_M1, 0);
        push("rst_m2", SEL_M2, 0);
        check_all();

        // stop=1 freezes everything, even with a paddle key held
        rst = 1'b0;
        up1 = 1'b1;
        ticks(3);
        push_reset_vals("stop_hold");
        check_all();

        // Paddle 1 climbs to 0 and clamps; paddle 2 with both keys stays put
        stop = 1'b0; up2 = 1'b1; down2 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            next_tick();
            push($sformatf("p1_up_%0d", k), SEL_P1, (200 - 4 * k < 0) ? 0 : 200 - 4 * k);
            push($sformatf("p2_both_%0d", k), SEL_P2, 200);
            check_all();
        end
        up1 = 1'b0; up2 = 1'b0; down2 = 1'b0;

        // Free ball run: bottom bounce, then right-edge miss
        rst = 1'b1; clk1(); rst = 1'b0;
        next_tick();
        push("serve_bx", SEL_BX, 316);
        push("serve_by", SEL_BY, 236);
        check_all();
        for (int m = 1; m <= 157; m++) begin
            next_tick();
            if (m == 118) push("bottom_bounce", SEL_BY, 472);
            if (m == 119) push("after_bounce", SEL_BY, 470);
            if (m == 157) begin
                push("pre_miss_bx", SEL_BX, 630);
                push("pre_miss_m2", SEL_M2, 0);
            end
            check_all();
        end
        next_tick();
        push("miss2_bx", SEL_BX, 632);
        push("miss2_by", SEL_BY, 392);
        push("miss2_pulse", SEL_M2, 1);
        push("miss2_no_m1", SEL_M1, 0);
        check_all();
        clk1();
        push("miss2_drop", SEL_M2, 0);
        check_all();
        ticks(2);
        push("missed_hold_bx", SEL_BX, 632);
        push("missed_hold_by", SEL_BY, 392);
        check_all();

        // Serve after miss2: centre, then ball heads right and down
        serve = 1'b1; clk1(); serve = 1'b0;
        push("served_bx", SEL_BX, 316);
        push("served_by", SEL_BY, 236);
        check_all();
        next_tick();
        push("serve_to_move_bx", SEL_BX, 316);
        check_all();
        next_tick();
        push("after_m2_bx", SEL_BX, 318);
        push("after_m2_by", SEL_BY, 238);
        check_all();
        speed_lvl = 2'd3;
        next_tick();
        push("speed3_bx", SEL_BX, 323);
        push("speed3_by", SEL_BY, 243);
        check_all();
        stop = 1'b1;
        ticks(3);
        push("stop_mid_bx", SEL_BX, 323);
        push("stop_mid_by", SEL_BY, 243);
        check_all();
        stop = 1'b0;
        next_tick();
        push("resume_bx", SEL_BX, 328);
        push("resume_by", SEL_BY, 248);
        check_all();
        rst = 1'b1; clk1(); rst = 1'b0;
        push_reset_vals("rst_mid");
        check_all();
        speed_lvl = 2'd0;

        // Paddle 2 parked at the bottom: right-face bounce, then left-edge miss
        down2 = 1'b1;
        next_tick();
        for (int m = 1; m <= 444; m++) begin
            next_tick();
            if (m == 142) begin
                push("pre_hit_bx", SEL_BX, 600);
                push("pre_hit_by", SEL_BY, 424);
                push("p2_clamp", SEL_P2, 400);
            end
            if (m == 143) push("hit_p2_bx", SEL_BX, 602);
            if (m == 144) push("rebound_bx", SEL_BX, 600);
            if (m == 354) push("top_bounce", SEL_BY, 0);
            if (m == 430) push("no_p1_hit", SEL_BX, 28);
            if (m == 443) push("pre_miss1_bx", SEL_BX, 2);
            if (m == 444) begin
                push("miss1_bx", SEL_BX, 0);
                push("miss1_pulse", SEL_M1, 1);
                push("miss1_no_m2", SEL_M2, 0);
            end
            check_all();
        end
        clk1();
        push("miss1_drop", SEL_M1, 0);
        check_all();
        down2 = 1'b0;

        // Serve after miss1: ball heads left
        serve = 1'b1; clk1(); serve = 1'b0;
        push("served1_bx", SEL_BX, 316);
        check_all();
        next_tick();
        next_tick();
        push("after_m1_bx", SEL_BX, 314);
        push("after_m1_by", SEL_BY, 238);
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
